// File: rtl/count_sequencer_pkg.sv
// count_sequencer_pkg
//   Shared definitions for the count sequencer: State encodings (also decoded
//   by the display top), number of edge-detected buttons, and the packed
//   button-event bundle passed from the edge detectors to the FSM.
package count_sequencer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    localparam int NUM_KEYS = 3;

    // Bit order matches the {Clear, Stop, Start} key vector in the top.
    typedef struct packed {
        logic clear;
        logic stop;
        logic start;
    } key_evt_t;

endpackage

// File: rtl/count_sequencer_key_edge.sv
// count_sequencer_key_edge
//   Rising-edge detector for one push-button level.
//   Ports:
//     Clock  in   board clock
//     Resetn in   synchronous active-low reset
//     Key    in   button level, active-high
//     Event  out  high in the cycle Key is first seen high
//   The history register resets to 1 so a button held through reset does
//   not produce an event when reset is released.
module count_sequencer_key_edge (
    input  logic Clock,
    input  logic Resetn,
    input  logic Key,
    output logic Event
);

    logic prev;

    always_ff @(posedge Clock) begin
        if (!Resetn) prev <= 1'b1;
        else         prev <= Key;
    end

    // Combinational from the registered history so the FSM reacts at the
    // same edge the press is sampled.
    assign Event = Key & ~prev;

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer
//   Run/stop controller for the 4-bit display counter. Divides the board
//   clock into count ticks, edge-detects Start/Stop/Clear and runs an
//   IDLE/RUN/PAUSE/DONE machine that stops or wraps at Limit.
//   Ports:
//     Clock        in   board clock
//     Resetn       in   synchronous active-low reset
//     Start        in   run/resume button level
//     Stop         in   pause button level
//     Clear        in   clear button level
//     Mode         in   0 = stop at Limit, 1 = wrap to 0 after Limit
//     Limit        in   terminal count, compared at each tick
//     Count        in   counter value fed back from the counter
//     CountEnable  out  one-cycle increment strobe
//     CountClear   out  one-cycle clear strobe
//     Running      out  State == RUN
//     Done         out  State == DONE
//     State        out  IDLE=00 RUN=01 PAUSE=10 DONE=11
module count_sequencer
    import count_sequencer_pkg::*;
#(
    parameter int PRESCALE  = 50000000,
    parameter int PS_WIDTH  = 26,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 Start,
    input  logic                 Stop,
    input  logic                 Clear,
    input  logic                 Mode,
    input  logic [CNT_WIDTH-1:0] Limit,
    input  logic [CNT_WIDTH-1:0] Count,
    output logic                 CountEnable,
    output logic                 CountClear,
    output logic                 Running,
    output logic                 Done,
    output logic [1:0]           State
);

    logic [NUM_KEYS-1:0] keys;
    logic [NUM_KEYS-1:0] evts;
    key_evt_t            evt;

    assign keys = {Clear, Stop, Start};

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        count_sequencer_key_edge u_key (
            .Clock  (Clock),
            .Resetn (Resetn),
            .Key    (keys[i]),
            .Event  (evts[i])
        );
    end

    assign evt = key_evt_t'(evts);

    logic [PS_WIDTH-1:0] prescaler;
    logic                tick;
    logic                at_limit;

    assign tick     = (prescaler == PS_WIDTH'(PRESCALE - 1));
    // >= rather than == so a Limit lowered below Count mid-run still ends
    // the run (or wraps) at the next tick.
    assign at_limit = (Count >= Limit);

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            State       <= ST_IDLE;
            prescaler   <= '0;
            CountEnable <= 1'b0;
            CountClear  <= 1'b0;
        end else begin
            CountEnable <= 1'b0;
            CountClear  <= 1'b0;
            if (evt.clear) begin
                CountClear <= 1'b1;
                prescaler  <= '0;
                State      <= ST_IDLE;
            end else begin
                case (State)
                    ST_IDLE: begin
                        if (evt.start) begin
                            State     <= ST_RUN;
                            prescaler <= '0;
                        end
                    end
                    ST_RUN: begin
                        // Stop beats tick; the prescaler keeps its value so
                        // a resume finishes the interrupted period.
                        if (evt.stop) begin
                            State <= ST_PAUSE;
                        end else if (tick) begin
                            prescaler <= '0;
                            if (!at_limit)  CountEnable <= 1'b1;
                            else if (Mode)  CountClear  <= 1'b1;
                            else            State       <= ST_DONE;
                        end else begin
                            prescaler <= prescaler + PS_WIDTH'(1);
                        end
                    end
                    ST_PAUSE: begin
                        if (evt.start) State <= ST_RUN;
                    end
                    ST_DONE: begin
                        // Restart from zero: clear the counter and the period.
                        if (evt.start) begin
                            State      <= ST_RUN;
                            prescaler  <= '0;
                            CountClear <= 1'b1;
                        end
                    end
                    default: State <= ST_IDLE;
                endcase
            end
        end
    end

    assign Running = (State == ST_RUN);
    assign Done    = (State == ST_DONE);

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer
//   Directed scenarios followed by randomized button/limit/mode traffic,
//   every cycle compared against a behavioural model of the sequencer and
//   a model of the 4-bit counter it drives.
module tb_count_sequencer;

    localparam int PRESCALE = 4;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       Clock  = 1'b0;
    logic       Resetn = 1'b0;
    logic       Start  = 1'b0;
    logic       Stop   = 1'b0;
    logic       Clear  = 1'b0;
    logic       Mode   = 1'b0;
    logic [3:0] Limit  = 4'd0;
    logic [3:0] Count;
    logic       CountEnable, CountClear, Running, Done;
    logic [1:0] State;

    count_sequencer #(.PRESCALE(PRESCALE), .PS_WIDTH(3), .CNT_WIDTH(4)) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .Start       (Start),
        .Stop        (Stop),
        .Clear       (Clear),
        .Mode        (Mode),
        .Limit       (Limit),
        .Count       (Count),
        .CountEnable (CountEnable),
        .CountClear  (CountClear),
        .Running     (Running),
        .Done        (Done),
        .State       (State)
    );

    always #5 Clock = ~Clock;

    // The display counter driven by the sequencer's strobes.
    logic [3:0] cnt = 4'd0;
    always @(posedge Clock) begin
        if (CountClear === 1'b1)       cnt <= 4'd0;
        else if (CountEnable === 1'b1) cnt <= cnt + 4'd1;
    end
    assign Count = cnt;

    int n_pass = 0;
    int n_total = 0;
    int n_ce = 0;
    int n_cc = 0;

    // Behavioural model: phase = cycles elapsed in the current count period.
    int m_state = M_IDLE;
    int m_phase = 0;
    int m_cnt   = 0;
    bit m_ce = 1'b0, m_cc = 1'b0;
    bit h_start = 1'b1, h_stop = 1'b1, h_clear = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance the model over one rising edge using the inputs as they stand.
    task automatic model_edge();
        bit s, p, c;
        int nxt_cnt;
        nxt_cnt = m_cc ? 0 : (m_ce ? (m_cnt + 1) % 16 : m_cnt);
        s = Start && !h_start;
        p = Stop  && !h_stop;
        c = Clear && !h_clear;
        m_ce = 1'b0;
        m_cc = 1'b0;
        if (!Resetn) begin
            m_state = M_IDLE;
            m_phase = 0;
            h_start = 1'b1; h_stop = 1'b1; h_clear = 1'b1;
        end else begin
            if (c) begin
                m_cc = 1'b1; m_phase = 0; m_state = M_IDLE;
            end else if (m_state == M_IDLE) begin
                if (s) begin m_state = M_RUN; m_phase = 0; end
            end else if (m_state == M_RUN) begin
                if (p) m_state = M_PAUSE;
                else if (m_phase == PRESCALE - 1) begin
                    m_phase = 0;
                    if (m_cnt < int'(Limit)) m_ce = 1'b1;
                    else if (Mode)           m_cc = 1'b1;
                    else                     m_state = M_DONE;
                end else m_phase++;
            end else if (m_state == M_PAUSE) begin
                if (s) m_state = M_RUN;
            end else begin
                if (s) begin m_state = M_RUN; m_cc = 1'b1; m_phase = 0; end
            end
            h_start = Start; h_stop = Stop; h_clear = Clear;
        end
        m_cnt = nxt_cnt;
    endtask

    task automatic step();
        model_edge();
        @(posedge Clock);
        #1;
        chk("state",   State,       m_state);
        chk("enable",  CountEnable, m_ce);
        chk("clear",   CountClear,  m_cc);
        chk("running", Running,     m_state == M_RUN);
        chk("done",    Done,        m_state == M_DONE);
        chk("count",   Count,       m_cnt);
        chk("excl",    CountEnable & CountClear, 0);
        if (CountEnable === 1'b1) n_ce++;
        if (CountClear === 1'b1)  n_cc++;
    endtask

    task automatic wait_ce(input string tag);
        int k;
        k = 0;
        while (CountEnable !== 1'b1 && k < 16) begin
            step();
            k++;
        end
        chk(tag, CountEnable, 1);
    endtask

    initial begin
        int first_ce;
        int trans;
        logic [1:0] last_st;
        logic [3:0] held;
        int seq[$];
        int exp_seq[5];

        // 1. Reset
        Resetn = 1'b0;
        step(); step();
        chk("rst_state", State, 0);
        chk("rst_ce", CountEnable, 0);
        chk("rst_cc", CountClear, 0);
        chk("rst_run", Running, 0);
        chk("rst_done", Done, 0);
        Resetn = 1'b1;
        step();

        // 2. Stop at Limit=3
        Mode = 1'b0; Limit = 4'd3;
        Start = 1'b1; step(); Start = 1'b0;
        n_ce = 0; first_ce = 0;
        for (int i = 1; i <= 18; i++) begin
            step();
            if (CountEnable === 1'b1 && first_ce == 0) first_ce = i;
        end
        chk("t2_first_ce", first_ce, 4);
        chk("t2_ce_count", n_ce, 3);
        chk("t2_state", State, 3);
        chk("t2_done", Done, 1);
        chk("t2_count", Count, 3);

        // 3. Wrap at Limit=2
        Clear = 1'b1; step(); Clear = 1'b0;
        Mode = 1'b1; Limit = 4'd2;
        Start = 1'b1; step(); Start = 1'b0;
        n_ce = 0; n_cc = 0;
        seq = {0};
        for (int i = 0; i < 17; i++) begin
            step();
            if (int'(Count) != seq[$]) seq.push_back(int'(Count));
        end
        exp_seq = '{0, 1, 2, 0, 1};
        chk("t3_seq_len", seq.size(), 5);
        for (int i = 0; i < 5 && i < seq.size(); i++) chk("t3_seq", seq[i], exp_seq[i]);
        chk("t3_ce_count", n_ce, 3);
        chk("t3_cc_count", n_cc, 1);

        // 4. Pause two cycles into a period, then resume
        Limit = 4'd15;
        wait_ce("t4_sync");
        step(); step();
        Stop = 1'b1; step(); Stop = 1'b0;
        step();
        held = Count;
        for (int i = 0; i < 10; i++) step();
        chk("t4_paused", State, 2);
        chk("t4_held", Count, held);
        Start = 1'b1; step(); Start = 1'b0;
        chk("t4_r0", CountEnable, 0);
        step();
        chk("t4_r1", CountEnable, 0);
        step();
        chk("t4_r2", CountEnable, 1);

        // 5. Start and Clear together, then a long Start press
        n_cc = 0;
        Start = 1'b1; Clear = 1'b1; step();
        chk("t5_state", State, 0);
        Start = 1'b0; Clear = 1'b0; step();
        chk("t5_cc_once", n_cc, 1);
        Start = 1'b1;
        trans = 0;
        for (int i = 0; i < 20; i++) begin
            last_st = State;
            step();
            if (last_st == 2'b00 && State == 2'b01) trans++;
        end
        chk("t5_one_start", trans, 1);

        // 6. Reset one cycle before a tick
        wait_ce("t6_sync");
        step(); step();
        Resetn = 1'b0; Start = 1'b0; step();
        chk("t6_rst_state", State, 0);
        Resetn = 1'b1; step();
        chk("t6_no_ce", CountEnable, 0);
        chk("t6_idle", State, 0);
        Start = 1'b1; step(); Start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("t6_pre", CountEnable, 0);
        end
        step();
        chk("t6_first", CountEnable, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            Start  = ($urandom_range(0, 7) == 0);
            Stop   = ($urandom_range(0, 11) == 0);
            Clear  = ($urandom_range(0, 39) == 0);
            Resetn = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 29) == 0) Limit = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) Mode = 1'($urandom_range(0, 1));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
